// File: rtl/dc_2b_seq_pkg.sv
// Shared types and constants for the dc_2b command sequencer.
// Holds the FSM encoding and the request entry width.
package dc_2b_seq_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int entry_w(input int tag_w);
    return tag_w + CNT_W;
  endfunction

endpackage

// File: rtl/dc_2b_seq_if.sv
// Request/done handshake bundle between producer and sequencer.
// The master side is the producer; the slave side is dc_2b_seq.
interface dc_2b_seq_if
  import dc_2b_seq_pkg::*;
#(
  parameter int TAG_W = 2
);

  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_delay;
  logic [TAG_W-1:0] req_tag;
  logic             done;
  logic [TAG_W-1:0] done_tag;

  modport master (
    output req_valid,
    output req_delay,
    output req_tag,
    input  req_ready,
    input  done,
    input  done_tag
  );

  modport slave (
    input  req_valid,
    input  req_delay,
    input  req_tag,
    output req_ready,
    output done,
    output done_tag
  );

endinterface

// File: rtl/dc_2b_seq_req_fifo.sv
// Small synchronous request FIFO with flush and occupancy count.
// Async active-low reset; pointers wrap modulo DEPTH.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;
  logic          rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign wr    = push & ~full & ~flush;
  assign rd    = pop & (count != '0) & ~flush;
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dc_2b_seq.sv
// Sequencer feeding queued delay requests to one dc_2b counter.
// Loads, counts down to zero, then pulses done with the request tag.
module dc_2b_seq
  import dc_2b_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  dc_2b_seq_if.slave       bus,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_enable,
  input  logic             cnt_zero,
  output logic             busy
);

  localparam int EW = entry_w(TAG_W);

  state_t                 state;
  logic [CNT_W-1:0]       cur_delay;
  logic [TAG_W-1:0]       cur_tag;
  logic [EW-1:0]          head;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   push;
  logic                   pop;

  assign bus.req_ready = ~full & ~flush;
  assign push = bus.req_valid & bus.req_ready;
  assign pop  = (state == IDLE) & (count != '0);

  req_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.req_delay, bus.req_tag}),
    .rdata (head),
    .full  (full),
    .count (count)
  );

  // Gate enable with zero so the counter can never wrap to 3.
  assign cnt_enable   = (state == RUN) & ~cnt_zero;
  assign cnt_load     = (state == LOAD);
  assign cnt_data     = (state == LOAD) ? cur_delay : '0;
  assign bus.done     = (state == DONE);
  assign bus.done_tag = (state == DONE) ? cur_tag : '0;
  assign busy         = (state != IDLE) | (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_delay <= '0;
      cur_tag   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            cur_delay <= head[TAG_W +: CNT_W];
            cur_tag   <= head[TAG_W-1:0];
            state     <= LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (cnt_zero) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_2b_seq.sv
// Directed bench for dc_2b_seq with a behavioural dc_2b attached.
// Linear step sequence; every check is an immediate assertion.
module tb_dc_2b_seq;
  import dc_2b_seq_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       cnt_load;
  logic       cnt_enable;
  logic       busy;
  logic [1:0] cnt_data;
  logic       cnt_zero;
  logic [1:0] cnt_m;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;
  logic [1:0] dq [$];

  dc_2b_seq_if #(.TAG_W(2)) bus ();

  dc_2b_seq #(
    .DEPTH (4),
    .TAG_W (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .cnt_load   (cnt_load),
    .cnt_data   (cnt_data),
    .cnt_enable (cnt_enable),
    .cnt_zero   (cnt_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // dc_2b behavioural model
  always @(posedge clk or negedge reset) begin
    if (!reset)          cnt_m <= 2'd0;
    else if (cnt_load)   cnt_m <= cnt_data;
    else if (cnt_enable) cnt_m <= cnt_m - 2'd1;
  end
  assign cnt_zero = (cnt_m == 2'd0);

  always @(negedge clk) begin
    if (bus.done) dq.push_back(bus.done_tag);
    if (cnt_enable && cnt_zero) viol++;
  end

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] t,
                      output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    bus.req_valid = 1'b1;
    bus.req_delay = d;
    bus.req_tag   = t;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.req_ready) ok = 1'b1;
      else waits++;
      tick(1);
    end
    bus.req_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    int w;
    logic [31:0] v;
    logic [1:0] exp4 [6];
    exp4 = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req_valid = 1'b0;
    bus.req_delay = 2'd0;
    bus.req_tag   = 2'd0;

    // reset state
    tick(2);
    chk("rst_load", cnt_load, 0);
    chk("rst_en", cnt_enable, 0);
    chk("rst_data", cnt_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tag", bus.done_tag, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick(1);
    chk("rst_ready", bus.req_ready, 1);

    // 1: async reset in the middle of RUN
    push(2'd3, 2'd3, w);
    tick(2);
    chk("t1_run_en", cnt_enable, 1);
    #2 reset = 1'b0;
    #1;
    chk("t1_load", cnt_load, 0);
    chk("t1_en", cnt_enable, 0);
    chk("t1_data", cnt_data, 0);
    chk("t1_done", bus.done, 0);
    chk("t1_busy", busy, 0);
    #1 reset = 1'b1;
    tick(1);
    chk("t1_ready", bus.req_ready, 1);
    chk("t1_busy2", busy, 0);

    // 2: delay 2, tag 1
    push(2'd2, 2'd1, w);
    chk("t2_busy", busy, 1);
    chk("t2_nobyp", cnt_load, 0);
    tick(1);
    chk("t2_load", cnt_load, 1);
    chk("t2_data", cnt_data, 2);
    tick(1);
    chk("t2_load_off", cnt_load, 0);
    chk("t2_en1", cnt_enable, 1);
    tick(1);
    chk("t2_en2", cnt_enable, 1);
    tick(1);
    chk("t2_en_off", cnt_enable, 0);
    chk("t2_cnt0", cnt_m, 0);
    tick(1);
    chk("t2_done", bus.done, 1);
    chk("t2_tag", bus.done_tag, 1);
    tick(1);
    chk("t2_done_off", bus.done, 0);
    chk("t2_idle", busy, 0);
    chk("t2_nowrap", cnt_m, 0);

    // 3: delay 0, tag 2
    push(2'd0, 2'd2, w);
    tick(1);
    chk("t3_load", cnt_load, 1);
    chk("t3_data", cnt_data, 0);
    tick(1);
    chk("t3_en", cnt_enable, 0);
    tick(1);
    chk("t3_done", bus.done, 1);
    chk("t3_tag", bus.done_tag, 2);
    tick(1);
    chk("t3_done_off", bus.done, 0);

    // 4: fill the FIFO behind a long request
    dq.delete();
    push(2'd3, 2'd3, w);
    push(2'd1, 2'd0, w);
    push(2'd0, 2'd1, w);
    push(2'd3, 2'd2, w);
    push(2'd2, 2'd3, w);
    chk("t4_full", bus.req_ready, 0);
    push(2'd1, 2'd0, w);
    chk("t4_waits", w, 4);
    for (int i = 0; i < 200 && dq.size() < 6; i++) tick(1);
    chk("t4_count", dq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      v = 'x;
      if (i < dq.size()) v = 32'(dq[i]);
      chk("t4_order", v, 32'(exp4[i]));
    end
    tick(2);
    chk("t4_idle", busy, 0);

    // 5: flush during RUN with two queued
    dq.delete();
    push(2'd3, 2'd1, w);
    push(2'd2, 2'd2, w);
    push(2'd1, 2'd3, w);
    chk("t5_run", cnt_enable, 1);
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_delay = 2'd1;
    bus.req_tag   = 2'd0;
    #1;
    chk("t5_ready", bus.req_ready, 0);
    tick(1);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_en", cnt_enable, 0);
    chk("t5_load", cnt_load, 0);
    tick(10);
    chk("t5_nodone", dq.size(), 0);
    chk("t5_busy2", busy, 0);

    // 6: push lands in the first IDLE cycle after DONE
    push(2'd1, 2'd2, w);
    tick(4);
    chk("t6_done1", bus.done, 1);
    chk("t6_tag1", bus.done_tag, 2);
    tick(1);
    push(2'd2, 2'd3, w);
    chk("t6_busy", busy, 1);
    chk("t6_nobyp", cnt_load, 0);
    tick(1);
    chk("t6_load", cnt_load, 1);
    chk("t6_data", cnt_data, 2);
    tick(3);
    chk("t6_early", bus.done, 0);
    tick(1);
    chk("t6_done2", bus.done, 1);
    chk("t6_tag2", bus.done_tag, 3);
    tick(1);
    chk("t6_idle", busy, 0);
    chk("t6_nowrap", cnt_m, 0);
    chk("no_wrap_viol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dc_2b_seq.md
Name: dc_2b_seq

Overview:
- Upstream command sequencer for the 2-bit down counter `dc_2b`.
- Accepts tagged delay requests into a small FIFO, then runs them one at a time:
  - loads the counter with the request's delay,
  - enables countdown until the counter's zero flag asserts,
  - emits a one-cycle done pulse carrying the request tag.
- Sits between the request producer and one `dc_2b` instance. It drives that instance's load/data/enable and consumes its zero.

Parameters:
- DEPTH, 4, request FIFO depth (power of 2, ≥2).
- TAG_W, 2, tag width per request.
- CNT_W, 2, delay/counter width. Fixed to match `dc_2b`; other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately.
- flush  in  1  synchronous abort: empty FIFO, drop the in-flight request.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept (not full and not flush).
- req_delay  in  CNT_W  countdown start value, 0..3.
- req_tag  in  TAG_W  opaque tag returned with done.
- cnt_load  out  1  to `dc_2b` load.
- cnt_data  out  CNT_W  to `dc_2b` data.
- cnt_enable  out  1  to `dc_2b` enable.
- cnt_zero  in  1  from `dc_2b` zero.
- done  out  1  one-cycle pulse, request completed.
- done_tag  out  TAG_W  tag of completed request; valid while done=1.
- busy  out  1  high in any state other than IDLE, or FIFO non-empty.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, FIFO empty (pointers and count = 0), latched delay/tag = 0.
  - Outputs: cnt_load=0, cnt_enable=0, cnt_data=0, done=0, done_tag=0, busy=0.
  - req_ready=1 once reset is released.
- Push: accepted on a rising edge where req_valid & req_ready. {req_delay, req_tag} is written at the write pointer.
- States (IDLE, LOAD, RUN, DONE):
  - IDLE: if FIFO non-empty (registered count), pop the head into cur_delay/cur_tag; next=LOAD.
  - LOAD: cnt_load=1, cnt_data=cur_delay; next=RUN. cnt_zero is ignored in LOAD because it reflects the stale count.
  - RUN: cnt_enable = ~cnt_zero (combinational gating). If cnt_zero=1, next=DONE. Enable must never be high while zero=1, otherwise the counter wraps to 3.
  - DONE: done=1, done_tag=cur_tag; next=IDLE.
- Latency, with the push accepted at edge E0 into an empty FIFO with the block idle:
  - pop at E1; LOAD during E1–E2; RUN for d+1 cycles (d = delay);
  - done high in the cycle after edge E(3+d);
  - throughput: one request per d+4 cycles.
- Outputs are decoded from state only. The single exception is cnt_enable, which also depends on cnt_zero.
- FIFO:
  - Full: req_ready=0; a push attempted while full is a no-op.
  - Simultaneous push and pop:
    - allowed when the FIFO is neither empty nor full; count is unchanged.
    - when the FIFO is empty, the pop does not see the new entry until the next cycle (no bypass).
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Flush (synchronous, highest priority after reset):
  - FIFO emptied, state→IDLE, no done issued.
  - req_ready=0 in the flush cycle; a coincident req_valid is dropped.
  - If flush coincides with DONE, the done pulse in that cycle still appears (it is decoded from the current state).
- Mid-operation reset: everything returns to reset values asynchronously. The external counter value is irrelevant afterwards, because every request begins with LOAD.
- Delay 0: RUN lasts exactly 1 cycle with cnt_enable=0.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3;
  - CNT_W=2;
  - the request entry width TAG_W+CNT_W.
- One natural sub-module, `req_fifo`: a parameterised synchronous FIFO with async active-low reset, flush, full/empty and count. The FSM stays in `dc_2b_seq`.
- `dc_2b` itself is not instantiated; it is connected at the parent level.

Test Plan:
1. Reset low mid-RUN (delay 3) → all outputs 0 immediately, busy=0; after release, req_ready=1.
2. Single request, delay=2, tag=1, with `dc_2b` model attached:
   - cnt_load for 1 cycle with data=2;
   - cnt_enable high 2 cycles then low when zero=1;
   - done=1, done_tag=1 five cycles after the accept edge;
   - counter ends at 0 (no wrap to 3).
3. Delay=0, tag=2 → cnt_enable never asserted; done 3 cycles after accept; done_tag=2.
4. Push 5 requests back-to-back (delays 1,0,3,2,1; tags 0..3,0) while busy:
   - req_ready drops when 4 are queued;
   - 5th is accepted only after the first pop;
   - done tags come out in order 0,1,2,3,0.
5. Flush during RUN with 2 entries queued → no done for the in-flight or queued requests; state IDLE next cycle; busy=0; a req_valid coincident with the flush is not accepted.
6. Push into an empty FIFO in the same cycle the FSM returns to IDLE → pop occurs one cycle later (no bypass); done timing still matches d+3 after the accept edge plus one.
